// File: rtl/log_natural_seq.sv
// -----------------------------------------------------------------------------
// log_natural_seq
//   Sequential natural logarithm of an unsigned Q8.8 operand.
//   The operand is normalised to a Q1.15 mantissa m in [1,2) and an exponent
//   k = p - 8, where p is the leading-one index. ln(m) is then built one term
//   per clock by greedy shift-add multiplicative normalisation: whenever
//   prod * (1 + 2^-i) still fits under m, the factor is taken and
//   ln(1 + 2^-i) is added to the accumulator. The result is
//   k * ln2 + acc as a signed Q15.16 value.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand x valid
//   in_ready   operand can be accepted (high only when idle)
//   x          unsigned Q8.8 operand
//   out_valid  result/err valid, held until out_ready
//   out_ready  consumer accepts the result
//   result     signed Q15.16 ln(x)
//   err        operand was zero (result forced to 0)
// -----------------------------------------------------------------------------
module log_natural_seq #(
    parameter int ITER    = 15,
    parameter int LN2_Q16 = 45426
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NORM    = 3'd1,
        ITERATE = 3'd2,
        SUM     = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [3:0]         ITER_C = 4'(ITER);
    localparam logic signed [31:0] LN2_C  = 32'(LN2_Q16);

    // round(ln(1 + 2^-i) * 2^16) for i = 1..15
    function automatic logic [15:0] ln_tab(input logic [3:0] idx);
        logic [15:0] val;
        case (idx)
            4'd1:    val = 16'd26573;
            4'd2:    val = 16'd14624;
            4'd3:    val = 16'd7719;
            4'd4:    val = 16'd3973;
            4'd5:    val = 16'd2017;
            4'd6:    val = 16'd1016;
            4'd7:    val = 16'd510;
            4'd8:    val = 16'd256;
            4'd9:    val = 16'd128;
            4'd10:   val = 16'd64;
            4'd11:   val = 16'd32;
            4'd12:   val = 16'd16;
            4'd13:   val = 16'd8;
            4'd14:   val = 16'd4;
            4'd15:   val = 16'd2;
            default: val = 16'd0;
        endcase
        return val;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [15:0]        x_r;
    logic [15:0]        m_r;
    logic signed [4:0]  k_r;
    logic [15:0]        prod_r;
    logic [15:0]        acc_r;
    logic [3:0]         i_r;
    logic [31:0]        result_r;
    logic               err_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic               accept_s;
    logic [3:0]         lead_s;
    logic [15:0]        m_s;
    logic signed [4:0]  k_s;
    logic [15:0]        shifted_s;
    logic [16:0]        cand_s;
    logic               take_s;
    logic signed [31:0] k_ext_s;
    logic signed [31:0] sum_s;

    assign accept_s = in_valid && in_ready_r;

    // Leading-one detection, normalisation and the shift-add candidate
    always_comb begin
        lead_s = 4'd0;
        for (int b = 0; b < 16; b++) begin
            lead_s = x_r[b] ? b[3:0] : lead_s;
        end
        m_s       = x_r << (4'd15 - lead_s);
        k_s       = $signed({1'b0, lead_s}) - 5'sd8;
        shifted_s = prod_r >> i_r;
        cand_s    = {1'b0, prod_r} + {1'b0, shifted_s};
        take_s    = (cand_s <= {1'b0, m_r});
        k_ext_s   = {{27{k_r[4]}}, k_r};
        sum_s     = (k_ext_s * LN2_C) + $signed({16'd0, acc_r});
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = NORM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            // A zero operand skips the iterations but still spends the SUM
            // slot, so its result appears two clocks after the accept.
            NORM: begin
                if (x_r == 16'd0) begin
                    state_nxt_s = SUM;
                end else begin
                    state_nxt_s = ITERATE;
                end
            end
            ITERATE: begin
                if (i_r == ITER_C) begin
                    state_nxt_s = SUM;
                end else begin
                    state_nxt_s = ITERATE;
                end
            end
            SUM: begin
                state_nxt_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

    // Datapath: operand latch, normalisation, iteration and final sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r      <= 16'd0;
            m_r      <= 16'd0;
            k_r      <= 5'sd0;
            prod_r   <= 16'd0;
            acc_r    <= 16'd0;
            i_r      <= 4'd0;
            result_r <= 32'd0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        x_r <= x;
                    end
                end
                NORM: begin
                    m_r    <= m_s;
                    k_r    <= k_s;
                    prod_r <= 16'h8000;
                    acc_r  <= 16'd0;
                    i_r    <= 4'd1;
                    if (x_r == 16'd0) begin
                        err_r    <= 1'b1;
                        result_r <= 32'd0;
                    end else begin
                        err_r    <= 1'b0;
                    end
                end
                ITERATE: begin
                    if (take_s) begin
                        prod_r <= cand_s[15:0];
                        acc_r  <= acc_r + ln_tab(i_r);
                    end
                    i_r <= i_r + 4'd1;
                end
                SUM: begin
                    if (err_r) begin
                        result_r <= 32'd0;
                    end else begin
                        result_r <= sum_s;
                        err_r    <= 1'b0;
                    end
                end
                default: begin
                    // DONE holds result and err stable
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign err       = err_r;

endmodule

// File: tb/tb_log_natural_seq.sv
// -----------------------------------------------------------------------------
// tb_log_natural_seq
//   Directed self-checking bench for log_natural_seq. Expected values are
//   hand-computed constants, a bit-exact model of the shift-add algorithm and
//   a tolerance check against the real natural logarithm.
// -----------------------------------------------------------------------------
module tb_log_natural_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    log_natural_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Bit-exact reference of normalisation + greedy shift-add
    function automatic logic [31:0] model_ln(input logic [15:0] xv);
        int tab [16] = '{0, 26573, 14624, 7719, 3973, 2017, 1016, 510,
                         256, 128, 64, 32, 16, 8, 4, 2};
        int p    = 0;
        int prod = 32768;
        int acc  = 0;
        int mm;
        int cand;
        for (int b = 0; b < 16; b++) begin
            if (xv[b]) p = b;
        end
        mm = (int'(xv) << (15 - p)) & 32'h0000FFFF;
        for (int i = 1; i <= 15; i++) begin
            cand = prod + (prod >> i);
            if (cand <= mm) begin
                prod = cand;
                acc  = acc + tab[i];
            end
        end
        return (p - 8) * 45426 + acc;
    endfunction

    task automatic chk_tol(input string tag, input logic [15:0] xv, input logic [31:0] obs);
        real r;
        int  rf;
        int  d;
        r  = $ln(real'(xv) / 256.0) * 65536.0;
        rf = (r < 0.0) ? $rtoi(r - 0.5) : $rtoi(r + 0.5);
        d  = $signed(obs) - rf;
        if (d < 0) d = -d;
        n_tests++;
        assert (d <= 16) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/-16", tag, $signed(obs), rf);
        end
    endtask

    // Present an operand once in_ready is seen, bounded wait
    task automatic send(input logic [15:0] xv);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk1("send_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        x        = xv;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count clocks from the accept edge until out_valid, bounded
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (out_valid !== 1'b1 && lat < 40);
    endtask

    // Accept the result and confirm return to IDLE on the next cycle
    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1({tag, "_ov_drop"}, out_valid, 1'b0);
        chk1({tag, "_ir_rise"}, in_ready, 1'b1);
    endtask

    initial begin
        int          lat;
        logic [31:0] held_res;
        logic        held_err;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk1 ("rst_in_ready",  in_ready,  1'b1);
        chk1 ("rst_out_valid", out_valid, 1'b0);
        chk32("rst_result",    result,    32'd0);
        chk1 ("rst_err",       err,       1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: ln(1.0) = 0, 17-clock latency
        send(16'h0100);
        wait_valid(lat);
        chk32("t1_lat",    32'(lat), 32'd17);
        chk32("t1_result", result,   32'h00000000);
        chk1 ("t1_err",    err,      1'b0);
        take("t1");

        // 2: exact powers of two -> k*LN2
        send(16'h0200);
        wait_valid(lat);
        chk32("t2a_lat",    32'(lat), 32'd17);
        chk32("t2a_result", result,   32'h0000B172);
        take("t2a");
        send(16'h0080);
        wait_valid(lat);
        chk32("t2b_result", result, 32'hFFFF4E8E);
        take("t2b");
        send(16'h0001);
        wait_valid(lat);
        chk32("t2c_result", result, 32'hFFFA7470);
        chk1 ("t2c_err",    err,    1'b0);
        take("t2c");

        // 3: zero operand -> err after 2 clocks, then a clean op
        send(16'h0000);
        wait_valid(lat);
        chk32("t3_lat",    32'(lat), 32'd2);
        chk1 ("t3_err",    err,      1'b1);
        chk32("t3_result", result,   32'd0);
        take("t3");
        send(16'h0200);
        wait_valid(lat);
        chk1 ("t3b_err",    err,    1'b0);
        chk32("t3b_result", result, 32'h0000B172);
        take("t3b");

        // 4: non-power-of-two operands vs model and real ln
        send(16'hFFFF);
        wait_valid(lat);
        chk32  ("t4a_model", result, model_ln(16'hFFFF));
        chk_tol("t4a_tol",   16'hFFFF, result);
        take("t4a");
        send(16'h01B4);
        wait_valid(lat);
        chk32  ("t4b_model", result, model_ln(16'h01B4));
        chk_tol("t4b_tol",   16'h01B4, result);
        take("t4b");
        send(16'h0003);
        wait_valid(lat);
        chk32  ("t4c_hand",  result, 32'hFFFB8DAF);
        chk32  ("t4c_model", result, model_ln(16'h0003));
        chk_tol("t4c_tol",   16'h0003, result);
        take("t4c");

        // 5: stall in DONE with in_valid pulses ignored
        send(16'h0300);
        wait_valid(lat);
        chk32("t5_result", result, 32'h0001193F);
        held_res = result;
        held_err = err;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            x        = 16'h0100;
            @(posedge clk); #1;
            chk1 ("t5_ov_hold",  out_valid, 1'b1);
            chk32("t5_res_hold", result,    held_res);
            chk1 ("t5_err_hold", err,       held_err);
            chk1 ("t5_ir_low",   in_ready,  1'b0);
        end
        in_valid = 1'b0;
        take("t5");
        @(posedge clk); #1;
        chk1("t5_no_phantom", in_ready, 1'b1);

        // 6: reset in the middle of the iterations
        send(16'h0200);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk1("t6_busy", in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk1 ("t6_rst_in_ready",  in_ready,  1'b1);
        chk1 ("t6_rst_out_valid", out_valid, 1'b0);
        chk32("t6_rst_result",    result,    32'd0);
        chk1 ("t6_rst_err",       err,       1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(16'h0080);
        wait_valid(lat);
        chk32("t6_lat",    32'(lat), 32'd17);
        chk32("t6_result", result,   32'hFFFF4E8E);
        take("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
